// File: rtl/aes_sbox_sched.sv
// Round-robin scheduler sharing one pipelined masked AES S-box between the state (port 0)
// and key-schedule (port 1) paths. Shares pass through untouched; they are never recombined here.
module aes_sbox_sched #(
    parameter int SHARES  = 2,
    parameter int LATENCY = 4,
    parameter int TAGW    = 4
) (
    input  logic                  ClkxCI,
    input  logic                  RstxBI,
    input  logic                  FlushxSI,
    input  logic                  Req0xSI,
    input  logic [TAGW-1:0]       Tag0xDI,
    input  logic [8*SHARES-1:0]   X0xDI,
    output logic                  Gnt0xSO,
    input  logic                  Req1xSI,
    input  logic [TAGW-1:0]       Tag1xDI,
    input  logic [8*SHARES-1:0]   X1xDI,
    output logic                  Gnt1xSO,
    output logic [8*SHARES-1:0]   SboxXxDO,
    input  logic [8*SHARES-1:0]   SboxQxDI,
    output logic                  RandEnxSO,
    output logic                  Rsp0xSO,
    output logic                  Rsp1xSO,
    output logic [TAGW-1:0]       RspTagxDO,
    output logic [8*SHARES-1:0]   RspQxDO,
    output logic                  BusyxSO
);
    localparam int W = 8 * SHARES;

    typedef struct packed {
        logic            v;
        logic            id;
        logic [TAGW-1:0] tag;
    } slot_t;

    // Stage 0 is loaded together with SboxXxDO; the tail lines up with SboxQxDI.
    slot_t [LATENCY-1:0] line_q, line_d;

    logic [W-1:0]    sbox_x_q, sbox_x_d;
    logic [W-1:0]    rspq_q, rspq_d;
    logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
    logic            rand_en_q, rand_en_d;
    logic            rsp0_q, rsp0_d;
    logic            rsp1_q, rsp1_d;
    logic            last_q, last_d;
    logic            gnt0, gnt1;
    logic            tail_live;
    logic            busy;
    slot_t           issue;

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        last_d    = last_q;
        sbox_x_d  = '0;
        rand_en_d = 1'b0;
        issue     = '0;
        line_d    = '0;

        if (!FlushxSI) begin
            gnt0 = Req0xSI && (!Req1xSI || last_q);
            gnt1 = Req1xSI && (!Req0xSI || !last_q);
        end

        if (gnt0) begin
            last_d    = 1'b0;
            sbox_x_d  = X0xDI;
            rand_en_d = 1'b1;
            issue     = '{v: 1'b1, id: 1'b0, tag: Tag0xDI};
        end else if (gnt1) begin
            last_d    = 1'b1;
            sbox_x_d  = X1xDI;
            rand_en_d = 1'b1;
            issue     = '{v: 1'b1, id: 1'b1, tag: Tag1xDI};
        end

        line_d[0] = issue;
        for (int i = 1; i < LATENCY; i++) begin
            line_d[i] = line_q[i-1];
        end
        // Flushed bytes keep draining through the S-box, but lose their valid bit.
        if (FlushxSI) begin
            for (int i = 0; i < LATENCY; i++) begin
                line_d[i].v = 1'b0;
            end
        end

        tail_live = line_q[LATENCY-1].v && !FlushxSI;
        rsp0_d    = tail_live && !line_q[LATENCY-1].id;
        rsp1_d    = tail_live && line_q[LATENCY-1].id;
        rsp_tag_d = tail_live ? line_q[LATENCY-1].tag : '0;
        rspq_d    = tail_live ? SboxQxDI : '0;
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | line_q[i].v;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            line_q    <= '0;
            sbox_x_q  <= '0;
            rand_en_q <= 1'b0;
            rsp0_q    <= 1'b0;
            rsp1_q    <= 1'b0;
            rsp_tag_q <= '0;
            rspq_q    <= '0;
            last_q    <= 1'b1;
        end else begin
            line_q    <= line_d;
            sbox_x_q  <= sbox_x_d;
            rand_en_q <= rand_en_d;
            rsp0_q    <= rsp0_d;
            rsp1_q    <= rsp1_d;
            rsp_tag_q <= rsp_tag_d;
            rspq_q    <= rspq_d;
            last_q    <= last_d;
        end
    end

    assign Gnt0xSO   = gnt0;
    assign Gnt1xSO   = gnt1;
    assign SboxXxDO  = sbox_x_q;
    assign RandEnxSO = rand_en_q;
    assign Rsp0xSO   = rsp0_q;
    assign Rsp1xSO   = rsp1_q;
    assign RspTagxDO = rsp_tag_q;
    assign RspQxDO   = rspq_q;
    assign BusyxSO   = busy;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Scoreboard bench for aes_sbox_sched: a behavioural masked S-box closes the loop, a driver pushes
// expected returns on every grant, and a negedge monitor pops and compares whenever a response appears.
module tb_aes_sbox_sched;
    localparam int SHARES  = 2;
    localparam int LATENCY = 4;
    localparam int TAGW    = 4;
    localparam int W       = 8 * SHARES;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            req0 = 1'b0, req1 = 1'b0;
    logic [TAGW-1:0] tag0 = '0, tag1 = '0;
    logic [W-1:0]    x0 = '0, x1 = '0;
    logic            gnt0, gnt1;
    logic [W-1:0]    sbox_x, sbox_q;
    logic            rand_en, rsp0, rsp1, busy;
    logic [TAGW-1:0] rsp_tag;
    logic [W-1:0]    rsp_q;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] sbox_tab [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    typedef struct {
        logic            id;
        logic [TAGW-1:0] tag;
        logic [7:0]      val;
        int              due;
    } exp_t;

    exp_t exp_q[$];

    aes_sbox_sched #(.SHARES(SHARES), .LATENCY(LATENCY), .TAGW(TAGW)) dut (
        .ClkxCI   (clk),
        .RstxBI   (rst_n),
        .FlushxSI (flush),
        .Req0xSI  (req0),
        .Tag0xDI  (tag0),
        .X0xDI    (x0),
        .Gnt0xSO  (gnt0),
        .Req1xSI  (req1),
        .Tag1xDI  (tag1),
        .X1xDI    (x1),
        .Gnt1xSO  (gnt1),
        .SboxXxDO (sbox_x),
        .SboxQxDI (sbox_q),
        .RandEnxSO(rand_en),
        .Rsp0xSO  (rsp0),
        .Rsp1xSO  (rsp1),
        .RspTagxDO(rsp_tag),
        .RspQxDO  (rsp_q),
        .BusyxSO  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External masked S-box: the scheduler's input register is its first stage, so LATENCY-1 more follow.
    function automatic logic [W-1:0] sbox_model(input logic [W-1:0] x);
        logic [7:0] m;
        m = x[7:0] ^ 8'h3C;
        return {sbox_tab[x[15:8] ^ x[7:0]] ^ m, m};
    endfunction

    logic [W-1:0] sb_pipe [LATENCY-1] = '{default: '0};
    always @(posedge clk) begin
        sb_pipe[0] <= sbox_model(sbox_x);
        for (int i = 1; i < LATENCY - 1; i++) sb_pipe[i] <= sb_pipe[i-1];
    end
    assign sbox_q = sb_pipe[LATENCY-2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: scoreboard pops on every response, plus issue-side checks against the previous cycle's grant.
    logic         prev_gnt = 1'b0;
    logic [W-1:0] prev_x = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_gnt = 1'b0;
            prev_x   = '0;
        end else begin
            check("rand_en", 32'(rand_en), 32'(prev_gnt));
            check("sbox_x", 32'(sbox_x), 32'(prev_x));
            if (rsp0 || rsp1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'({rsp1, rsp0}), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_port", 32'({rsp1, rsp0}), e.id ? 32'd2 : 32'd1);
                    check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                    check("rsp_val", 32'(rsp_q[15:8] ^ rsp_q[7:0]), 32'(e.val));
                    check("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                check("idle_rspq", 32'(rsp_q), 32'd0);
            end
            prev_gnt = gnt0 | gnt1;
            prev_x   = gnt0 ? x0 : (gnt1 ? x1 : '0);
        end
    end

    // One cycle of stimulus, entered and left at posedge+1; expectations are pushed on grant.
    task automatic cycle(input logic r0, input logic [TAGW-1:0] t0, input logic [W-1:0] d0, input logic [7:0] e0,
                         input logic r1, input logic [TAGW-1:0] t1, input logic [W-1:0] d1, input logic [7:0] e1,
                         input bit push, output logic g0, output logic g1);
        req0 = r0; tag0 = t0; x0 = d0;
        req1 = r1; tag1 = t1; x1 = d1;
        @(negedge clk);
        g0 = gnt0;
        g1 = gnt1;
        if (push && g0) exp_q.push_back('{1'b0, t0, e0, cyc + LATENCY + 1});
        if (push && g1) exp_q.push_back('{1'b1, t1, e1, cyc + LATENCY + 1});
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_sbox_x"}, 32'(sbox_x), 32'd0);
        check({name, "_rand_en"}, 32'(rand_en), 32'd0);
        check({name, "_rsp"}, 32'({rsp1, rsp0}), 32'd0);
        check({name, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
        check({name, "_rsp_q"}, 32'(rsp_q), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic g0, g1;
        int   g_last;
        logic [3:0] tg0, tg1;

        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Port 0 alone: byte 0x00 as {0x5A,0x5A}, tag 3 -> 0x63.
        cycle(1'b1, 4'd3, 16'h5A5A, 8'h63, 1'b0, '0, '0, 8'h00, 1'b1, g0, g1);
        check("t1_gnt0", 32'(g0), 32'd1);
        drain("t1_drain");

        // Port 1 streams tags 0..15 back-to-back with byte = tag.
        for (int t = 0; t < 16; t++) begin
            cycle(1'b0, '0, '0, 8'h00, 1'b1, 4'(t), {8'(t) ^ 8'h96, 8'h96}, sbox_tab[t], 1'b1, g0, g1);
            check("t3_gnt1", 32'(g1), 32'd1);
        end
        g_last = cyc - 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t3_busy", 32'(busy), (cyc - g_last) <= LATENCY ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        drain("t3_drain");

        // Both ports held: port 0 bytes 0x53 -> 0xED, port 1 bytes 0x01 -> 0x7C, grants alternate from port 0.
        tg0 = 4'd0;
        tg1 = 4'd8;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, tg0, 16'h1241, 8'hED, 1'b1, tg1, 16'hF0F1, 8'h7C, 1'b1, g0, g1);
            check("t2_gnt0", 32'(g0), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_gnt1", 32'(g1), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (g0) tg0 = tg0 + 4'd1;
            if (g1) tg1 = tg1 + 4'd1;
        end
        drain("t2_drain");

        // Three grants, then a flush two cycles later: none of them returns, no grant during flush.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 4'(10 + k), 16'h1122, 8'hC3, 1'b0, '0, '0, 8'h00, 1'b0, g0, g1);
            check("t4_pre_gnt", 32'(g0), 32'd1);
        end
        idle(1);
        flush = 1'b1;
        cycle(1'b1, 4'd14, 16'h1122, 8'hC3, 1'b0, '0, '0, 8'h00, 1'b0, g0, g1);
        check("t4_flush_gnt", 32'(g0), 32'd0);
        flush = 1'b0;
        cycle(1'b1, 4'd13, 16'h1122, 8'hC3, 1'b0, '0, '0, 8'h00, 1'b1, g0, g1);
        check("t4_post_gnt", 32'(g0), 32'd1);
        drain("t4_drain");

        // Reset mid-stream after port 0 was granted last; port 0 must still win the first tie afterwards.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 4'(k), 16'h5A5A, 8'h63, 1'b0, '0, '0, 8'h00, 1'b1, g0, g1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        idle(2);
        rst_n = 1'b1;
        cycle(1'b1, 4'd5, 16'h5A5A, 8'h63, 1'b1, 4'd6, 16'hF0F1, 8'h7C, 1'b1, g0, g1);
        check("t5_tie_gnt0", 32'(g0), 32'd1);
        check("t5_tie_gnt1", 32'(g1), 32'd0);
        drain("t5_drain");

        // Every share pair on port 0, with one idle cycle after each block of 256.
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                cycle(1'b1, 4'(j), {8'(i), 8'(j)}, sbox_tab[8'(i) ^ 8'(j)], 1'b0, '0, '0, 8'h00, 1'b1, g0, g1);
                check("t6_gnt0", 32'(g0), 32'd1);
            end
            idle(1);
        end
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
